// File: rtl/rob_commit_if.sv
// Dispatch, writeback, register-file and operand-query signals of the reorder buffer.
// The master modport is the pipeline side and the slave modport is the ROB.
interface rob_commit_if;
    logic        alloc_req;
    logic [4:0]  alloc_rd;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;

    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_data;

    logic        rf_load;
    logic        rf_allocate;
    logic [4:0]  rf_dest;
    logic [31:0] rf_data;
    logic [2:0]  rf_tag;

    logic [2:0]  q_tag_a;
    logic [2:0]  q_tag_b;
    logic        q_ready_a;
    logic        q_ready_b;
    logic [31:0] q_data_a;
    logic [31:0] q_data_b;

    logic        rob_empty;
    logic        rob_full;

    modport master (
        output alloc_req, alloc_rd, cdb_valid, cdb_tag, cdb_data, q_tag_a, q_tag_b,
        input  alloc_ready, alloc_tag, rf_load, rf_allocate, rf_dest, rf_data, rf_tag,
        input  q_ready_a, q_ready_b, q_data_a, q_data_b, rob_empty, rob_full
    );

    modport slave (
        input  alloc_req, alloc_rd, cdb_valid, cdb_tag, cdb_data, q_tag_a, q_tag_b,
        output alloc_ready, alloc_tag, rf_load, rf_allocate, rf_dest, rf_data, rf_tag,
        output q_ready_a, q_ready_b, q_data_a, q_data_b, rob_empty, rob_full
    );
endinterface

// File: rtl/rob_commit.sv
// 8-entry reorder buffer: in-order allocate, out-of-order writeback, in-order commit
// to a register file that shares one destination port between allocate and commit.
module rob_commit (
    input logic          clk,
    input logic          rst,
    rob_commit_if.slave  rob_io
);

    logic [7:0]  busy_q, busy_d;
    logic [7:0]  done_q, done_d;
    logic [4:0]  rd_q   [8];
    logic [4:0]  rd_d   [8];
    logic [31:0] data_q [8];
    logic [31:0] data_d [8];
    logic [2:0]  head_q, head_d;
    logic [2:0]  tail_q, tail_d;
    logic [3:0]  count_q, count_d;

    logic commit_fire;
    logic alloc_fire;
    logic byp_a, byp_b;

    // Commit owns the shared dest port, so it blocks allocation in the same cycle.
    assign commit_fire        = !rst && busy_q[head_q] && done_q[head_q];
    assign rob_io.alloc_ready = !rst && (count_q < 4'd8) && !commit_fire;
    assign rob_io.alloc_tag   = tail_q;
    assign alloc_fire         = rob_io.alloc_req && rob_io.alloc_ready;

    assign rob_io.rob_empty = rst || (count_q == 4'd0);
    assign rob_io.rob_full  = !rst && (count_q == 4'd8);

    always_comb begin
        busy_d  = busy_q;
        done_d  = done_q;
        rd_d    = rd_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rob_io.cdb_valid && busy_q[rob_io.cdb_tag]) begin
            data_d[rob_io.cdb_tag] = rob_io.cdb_data;
            done_d[rob_io.cdb_tag] = 1'b1;
        end
        if (alloc_fire) begin
            busy_d[tail_q] = 1'b1;
            done_d[tail_q] = 1'b0;
            rd_d[tail_q]   = rob_io.alloc_rd;
            tail_d         = tail_q + 3'd1;
            count_d        = count_q + 4'd1;
        end
        // Applied after writeback so a late result for the head cannot revive it.
        if (commit_fire) begin
            busy_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
            head_d         = head_q + 3'd1;
            count_d        = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_q   <= rd_d;
        data_q <= data_d;
    end

    always_comb begin
        rob_io.rf_load     = 1'b0;
        rob_io.rf_allocate = 1'b0;
        rob_io.rf_dest     = '0;
        rob_io.rf_data     = '0;
        rob_io.rf_tag      = '0;
        if (commit_fire) begin
            rob_io.rf_load = (rd_q[head_q] != 5'd0);
            rob_io.rf_dest = rd_q[head_q];
            rob_io.rf_data = data_q[head_q];
            rob_io.rf_tag  = head_q;
        end else if (alloc_fire) begin
            rob_io.rf_allocate = (rob_io.alloc_rd != 5'd0);
            rob_io.rf_dest     = rob_io.alloc_rd;
            rob_io.rf_tag      = tail_q;
        end
    end

    // Same-cycle CDB bypass takes precedence over stored results.
    assign byp_a = rob_io.cdb_valid && (rob_io.cdb_tag == rob_io.q_tag_a) && busy_q[rob_io.q_tag_a];
    assign byp_b = rob_io.cdb_valid && (rob_io.cdb_tag == rob_io.q_tag_b) && busy_q[rob_io.q_tag_b];

    assign rob_io.q_ready_a = !rst && (byp_a || (busy_q[rob_io.q_tag_a] && done_q[rob_io.q_tag_a]));
    assign rob_io.q_ready_b = !rst && (byp_b || (busy_q[rob_io.q_tag_b] && done_q[rob_io.q_tag_b]));

    assign rob_io.q_data_a = !rob_io.q_ready_a ? 32'd0 :
                             byp_a ? rob_io.cdb_data : data_q[rob_io.q_tag_a];
    assign rob_io.q_data_b = !rob_io.q_ready_b ? 32'd0 :
                             byp_b ? rob_io.cdb_data : data_q[rob_io.q_tag_b];

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: a per-cycle vector table plus hand sequences for
// full/wrap and mid-run reset.
module tb_rob_commit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    rob_commit_if bus ();

    rob_commit dut (
        .clk    (clk),
        .rst    (rst),
        .rob_io (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        req;
        logic [4:0]  rd;
        logic        cv;
        logic [2:0]  ctag;
        logic [31:0] cdata;
        logic [2:0]  qa;
        logic [2:0]  qb;
        logic        ready;
        logic [2:0]  tag;
        logic        load;
        logic        alloc;
        logic [4:0]  dest;
        logic [31:0] data;
        logic [2:0]  rtag;
        logic        rqa;
        logic [31:0] dqa;
        logic        rqb;
        logic [31:0] dqb;
        logic        empty;
        logic        full;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic r, input logic req, input logic [4:0] rd, input logic cv,
        input logic [2:0] ctag, input logic [31:0] cdata, input logic [2:0] qa,
        input logic [2:0] qb, input logic ready, input logic [2:0] tag, input logic load,
        input logic alloc, input logic [4:0] dest, input logic [31:0] data,
        input logic [2:0] rtag, input logic rqa, input logic [31:0] dqa, input logic rqb,
        input logic [31:0] dqb, input logic empty, input logic full);
        vec_t v;
        v.rst = r; v.req = req; v.rd = rd; v.cv = cv; v.ctag = ctag; v.cdata = cdata;
        v.qa = qa; v.qb = qb; v.ready = ready; v.tag = tag; v.load = load; v.alloc = alloc;
        v.dest = dest; v.data = data; v.rtag = rtag; v.rqa = rqa; v.dqa = dqa;
        v.rqb = rqb; v.dqb = dqb; v.empty = empty; v.full = full;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic req, input logic [4:0] rd,
                         input logic cv, input logic [2:0] ctag, input logic [31:0] cdata);
        @(negedge clk);
        rst           = r;
        bus.alloc_req = req;
        bus.alloc_rd  = rd;
        bus.cdb_valid = cv;
        bus.cdb_tag   = ctag;
        bus.cdb_data  = cdata;
        bus.q_tag_a   = 3'd0;
        bus.q_tag_b   = 3'd0;
        #1;
    endtask

    initial begin
        //           rst req rd cv ct cdata         qa qb | rdy tag ld al dst data rt
        //           rqa dqa rqb dqb emp full
        vecs[0]  = mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[1]  = mk(0, 1, 5, 0, 0, 0, 0, 0, 1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[2]  = mk(0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 1, 1, 1, 0, 0, 0, 0, 0,
                      1, 32'hDEADBEEF, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 5, 32'hDEADBEEF, 0,
                      1, 32'hDEADBEEF, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[5]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[6]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[7]  = mk(0, 1, 2, 0, 0, 0, 0, 0, 1, 1, 0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0);
        vecs[8]  = mk(0, 1, 3, 0, 0, 0, 0, 0, 1, 2, 0, 1, 3, 0, 2, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(0, 0, 0, 1, 2, 32'h22, 2, 1, 1, 3, 0, 0, 0, 0, 0,
                      1, 32'h22, 0, 0, 0, 0);
        vecs[10] = mk(0, 0, 0, 1, 1, 32'h11, 2, 1, 1, 3, 0, 0, 0, 0, 0,
                      1, 32'h22, 1, 32'h11, 0, 0);
        vecs[11] = mk(0, 0, 0, 1, 0, 32'h10, 0, 2, 1, 3, 0, 0, 0, 0, 0,
                      1, 32'h10, 1, 32'h22, 0, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 1, 32'h10, 0,
                      1, 32'h10, 1, 32'h10, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 1, 0, 2, 32'h11, 1,
                      0, 0, 1, 32'h11, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 3, 1, 0, 3, 32'h22, 2,
                      0, 0, 1, 32'h22, 0, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[16] = mk(0, 1, 7, 0, 0, 0, 0, 0, 1, 3, 0, 1, 7, 0, 3, 0, 0, 0, 0, 1, 0);
        vecs[17] = mk(0, 1, 8, 1, 3, 32'h77, 3, 0, 1, 4, 0, 1, 8, 0, 4,
                      1, 32'h77, 0, 0, 0, 0);
        vecs[18] = mk(0, 1, 9, 0, 0, 0, 3, 4, 0, 5, 1, 0, 7, 32'h77, 3,
                      1, 32'h77, 0, 0, 0, 0);
        vecs[19] = mk(0, 1, 9, 0, 0, 0, 0, 0, 1, 5, 0, 1, 9, 0, 5, 0, 0, 0, 0, 0, 0);
        vecs[20] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0);
        vecs[21] = mk(0, 0, 0, 1, 4, 32'h44, 6, 4, 1, 7, 0, 0, 0, 0, 0,
                      0, 0, 1, 32'h44, 0, 0);
        vecs[22] = mk(0, 0, 0, 1, 5, 32'h55, 5, 4, 0, 7, 1, 0, 8, 32'h44, 4,
                      1, 32'h55, 1, 32'h44, 0, 0);
        vecs[23] = mk(0, 0, 0, 1, 6, 32'h66, 6, 0, 0, 7, 1, 0, 9, 32'h55, 5,
                      1, 32'h66, 0, 0, 0, 0);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 6, 0, 0, 7, 0, 0, 0, 32'h66, 6,
                      1, 32'h66, 0, 0, 0, 0);
        vecs[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        bus.alloc_req = 1'b0;
        bus.alloc_rd  = '0;
        bus.cdb_valid = 1'b0;
        bus.cdb_tag   = '0;
        bus.cdb_data  = '0;
        bus.q_tag_a   = '0;
        bus.q_tag_b   = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst           = vecs[i].rst;
            bus.alloc_req = vecs[i].req;
            bus.alloc_rd  = vecs[i].rd;
            bus.cdb_valid = vecs[i].cv;
            bus.cdb_tag   = vecs[i].ctag;
            bus.cdb_data  = vecs[i].cdata;
            bus.q_tag_a   = vecs[i].qa;
            bus.q_tag_b   = vecs[i].qb;
            #1;
            chk($sformatf("v%0d alloc_ready", i), 32'(bus.alloc_ready), 32'(vecs[i].ready));
            chk($sformatf("v%0d alloc_tag", i), 32'(bus.alloc_tag), 32'(vecs[i].tag));
            chk($sformatf("v%0d rf_load", i), 32'(bus.rf_load), 32'(vecs[i].load));
            chk($sformatf("v%0d rf_allocate", i), 32'(bus.rf_allocate), 32'(vecs[i].alloc));
            chk($sformatf("v%0d rf_dest", i), 32'(bus.rf_dest), 32'(vecs[i].dest));
            chk($sformatf("v%0d rf_data", i), bus.rf_data, vecs[i].data);
            chk($sformatf("v%0d rf_tag", i), 32'(bus.rf_tag), 32'(vecs[i].rtag));
            chk($sformatf("v%0d q_ready_a", i), 32'(bus.q_ready_a), 32'(vecs[i].rqa));
            chk($sformatf("v%0d q_data_a", i), bus.q_data_a, vecs[i].dqa);
            chk($sformatf("v%0d q_ready_b", i), 32'(bus.q_ready_b), 32'(vecs[i].rqb));
            chk($sformatf("v%0d q_data_b", i), bus.q_data_b, vecs[i].dqb);
            chk($sformatf("v%0d rob_empty", i), 32'(bus.rob_empty), 32'(vecs[i].empty));
            chk($sformatf("v%0d rob_full", i), 32'(bus.rob_full), 32'(vecs[i].full));
        end

        // Fill all eight entries, then free one and see the tail wrap to tag 0.
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 5'(i + 1), 0, 0, 0);
            chk($sformatf("fill%0d alloc_ready", i), 32'(bus.alloc_ready), 1);
            chk($sformatf("fill%0d alloc_tag", i), 32'(bus.alloc_tag), i);
        end
        drive(0, 1, 5'd20, 0, 0, 0);
        chk("full rob_full", 32'(bus.rob_full), 1);
        chk("full alloc_ready", 32'(bus.alloc_ready), 0);
        chk("full rf_allocate", 32'(bus.rf_allocate), 0);
        drive(0, 1, 5'd20, 1, 0, 32'hA5A5_0000);
        chk("full wb alloc_ready", 32'(bus.alloc_ready), 0);
        drive(0, 1, 5'd20, 0, 0, 0);
        chk("wrap commit rf_load", 32'(bus.rf_load), 1);
        chk("wrap commit rf_dest", 32'(bus.rf_dest), 1);
        chk("wrap commit rf_data", bus.rf_data, 32'hA5A5_0000);
        chk("wrap commit alloc_ready", 32'(bus.alloc_ready), 0);
        drive(0, 1, 5'd20, 0, 0, 0);
        chk("wrap alloc_ready", 32'(bus.alloc_ready), 1);
        chk("wrap alloc_tag", 32'(bus.alloc_tag), 0);
        chk("wrap rob_full", 32'(bus.rob_full), 0);
        chk("wrap rf_tag", 32'(bus.rf_tag), 0);

        // Four in flight, head ready to commit, then reset lands on the commit cycle.
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 5'(i + 4), 0, 0, 0);
        drive(0, 0, 0, 1, 0, 32'h1234);
        drive(1, 0, 0, 0, 0, 0);
        chk("rst rf_load", 32'(bus.rf_load), 0);
        chk("rst alloc_ready", 32'(bus.alloc_ready), 0);
        chk("rst rob_empty", 32'(bus.rob_empty), 1);
        chk("rst q_ready_a", 32'(bus.q_ready_a), 0);
        chk("rst rf_dest", 32'(bus.rf_dest), 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("post-rst rob_empty", 32'(bus.rob_empty), 1);
        chk("post-rst rf_load", 32'(bus.rf_load), 0);
        drive(0, 1, 5'd3, 0, 0, 0);
        chk("post-rst alloc_tag", 32'(bus.alloc_tag), 0);
        chk("post-rst alloc_ready", 32'(bus.alloc_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
